bcd_to_excess3_seq: RTL and testbench
=====================================

Name: bcd_to_excess3_seq

Overview:
- Sequential multi-digit converter from packed BCD to packed excess-3 (XS3); the encode direction matching the team's excess3tobcd decoder.
- Accepts one packed BCD word through a valid/ready handshake.
- Converts one digit per clock, least-significant digit first, and presents the XS3 word with an error flag on a valid/ready output.
- Sits between the BCD counter/keypad path and the XS3 display/transmit path.

Parameters:
- DIGITS, 4, number of BCD digits per word; must be ≥1. Data width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bcd holds a word.
- in_ready  output  1  block accepts a word; high exactly when state is IDLE.
- in_bcd  input  4*DIGITS  packed BCD; digit i is bits [4i+3:4i].
- out_valid  output  1  out_xs3/out_err valid; high exactly when state is DONE.
- out_ready  input  1  consumer takes the result.
- out_xs3  output  4*DIGITS  packed XS3 result.
- out_err  output  1  at least one input digit was greater than 9.
- busy  output  1  state is CONV.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; shift/capture register, digit counter, out_xs3 and out_err all 0.
  - out_valid=0, busy=0.
  - in_ready=1 while in reset, but in_valid is ignored until rst_n is high at a clock edge.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - On an edge with in_valid & in_ready: capture in_bcd, clear counter, clear out_xs3 and out_err, go to CONV.
  - Otherwise stay in IDLE.
- CONV, one digit per edge (digit index = counter, LSD first):
  - For digit d: if d ≤ 9, xs3 = d + 3 (4-bit, no carry out). If d ≥ 10, xs3 = 4'b0000 (not a legal XS3 code) and out_err is set sticky.
  - Write xs3 into out_xs3 bits [4i+3:4i] and increment the counter.
  - On the edge that converts digit DIGITS-1, go to DONE.
  - Counter width is clog2(DIGITS), minimum 1 bit. The counter never wraps inside a word and is cleared on accept.
- DONE:
  - out_valid=1; out_xs3 and out_err stay stable until the handshake.
  - On an edge with out_valid & out_ready, go to IDLE.
- Latency: out_valid rises DIGITS edges after the accepting edge.
- Throughput: one word per DIGITS+2 cycles with in_valid and out_ready held high.
- in_ready is low in CONV and DONE, so no new word is accepted during conversion or backpressure.
- Input changes during CONV have no effect, because data is captured at accept.
- out_ready asserted outside DONE is ignored.
- Reset mid-CONV or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.
- DIGITS=1: CONV lasts one cycle.
- All outputs come from registers or are decoded from state; there is no combinational path from input to output data.

Decomposition:
- Package xs3_pkg holds:
  - State encoding constants: IDLE=2'd0, CONV=2'd1, DONE=2'd2.
  - XS3_OFFSET=4'd3.
  - XS3_INVALID=4'd0.
  - BCD_MAX=4'd9.
- Sub-module bcd_digit_to_xs3: combinational, 4-bit digit in, 4-bit xs3 out plus a 1-bit err.
- The top level instantiates bcd_digit_to_xs3 once and time-multiplexes it over the digits under FSM control.

Test Plan:
- DIGITS=4, in_bcd=16'h0259, out_ready=1 → out_xs3=16'h358C, out_err=0, out_valid rises 4 edges after accept and lasts 1 cycle.
- in_bcd=16'h9999 then 16'h0000 back-to-back, in_valid held high → outputs 16'hCCCC then 16'h3333, accepts 6 cycles apart, err=0 for both.
- in_bcd=16'h12A4 → out_xs3=16'h4507, out_err=1. Next word 16'h0001 → 16'h3334 with out_err=0 (the sticky error was cleared at accept).
- 16'h0714 with out_ready low for 10 cycles → out_valid stays 1, out_xs3=16'h3A47 stays stable, in_ready=0 throughout; handshake on the first cycle out_ready=1, and in_ready=1 on the next cycle.
- Reset asserted 2 cycles into CONV → out_valid=0, out_xs3=0, busy=0 immediately. After release, 16'h8765 → 16'hBA98 with normal latency.
- Round trip: random legal BCD words go through this block, then one excess3tobcd per digit; the decoded word equals the input for all 10^4 values with DIGITS=4.

Source files
------------

// File: rtl/xs3_pkg.sv
// Shared encodings for the BCD to excess-3 encoder: FSM states and digit constants.
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] XS3_INVALID = 4'd0;
  localparam logic [3:0] BCD_MAX     = 4'd9;

endpackage

// File: rtl/bcd_digit_to_xs3.sv
// Single-digit BCD to excess-3 encoder, purely combinational.
// Digits above 9 map to the illegal code 0000 and raise o_err.
module bcd_digit_to_xs3
  import xs3_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_xs3,
  output logic       o_err
);

  assign o_err = (i_digit > BCD_MAX);
  assign o_xs3 = o_err ? XS3_INVALID : (i_digit + XS3_OFFSET);

endmodule

// File: rtl/bcd_to_excess3_seq.sv
// Multi-digit BCD to excess-3 encoder: captures a word, converts one digit per clock
// LSD first through a shared digit encoder, then holds the result until taken.
module bcd_to_excess3_seq
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_xs3,
  output logic                  out_err,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_bcd;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_xs3;
  logic            r_err;
  logic [3:0]      w_digit_xs3;
  logic            w_digit_err;
  logic            w_last;

  assign w_last = (r_cnt == LAST_IDX);

  // The capture register shifts right each CONV cycle, so the digit under conversion is always the low nibble.
  bcd_digit_to_xs3 u_digit (
    .i_digit (r_bcd[3:0]),
    .o_xs3   (w_digit_xs3),
    .o_err   (w_digit_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = CONV;
      CONV:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_cnt <= '0;
      r_xs3 <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bcd <= in_bcd;
            r_cnt <= '0;
            r_xs3 <= '0;
            r_err <= 1'b0;
          end
        end
        CONV: begin
          r_bcd <= r_bcd >> 4;
          for (int i = 0; i < DIGITS; i++) begin
            if (r_cnt == CW'(i)) begin
              r_xs3[i*4 +: 4] <= w_digit_xs3;
            end
          end
          if (w_digit_err) begin
            r_err <= 1'b1;
          end
          // Hold on the last digit so the index never wraps inside a word.
          if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == CONV);
  assign out_xs3   = r_xs3;
  assign out_err   = r_err;

endmodule

// File: tb/tb_bcd_to_excess3_seq.sv
// Scoreboard bench for bcd_to_excess3_seq with DIGITS=4: directed scenarios plus a
// full round trip of all legal 4-digit BCD words through an excess-3 decode model.
module tb_bcd_to_excess3_seq;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int NWORDS = 10000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_bcd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_xs3;
  logic         out_err;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] rt_q[$];

  always #5 clk = ~clk;

  bcd_to_excess3_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xs3   (out_xs3),
    .out_err   (out_err),
    .busy      (busy)
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference excess-3 decoder: subtract 3 from each nibble.
  function automatic logic [W-1:0] xs3_decode(input logic [W-1:0] x);
    logic [W-1:0] d;
    d = '0;
    for (int i = 0; i < DIGITS; i++) d[i*4 +: 4] = x[i*4 +: 4] - 4'd3;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [W-1:0] w);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    in_bcd   = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_bcd    = 16'h1234;
    out_ready = 1'b0;
    #2;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_xs3 !== '0 || out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%b vld=%b busy=%b xs3=%h err=%b, want 1 0 0 0000 0",
               in_ready, out_valid, busy, out_xs3, out_err);
    end
    step();
    step();
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ignores_valid: busy=%b rdy=%b, want 0 1", busy, in_ready);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b rdy=%b vld=%b, want 0 1 0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [W:0] e;
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 16'h358C});
    drive_word(16'h0259);
    in_bcd = 16'hFFFF;
    wait_valid(lat);
    n_vec++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d edges, want 4", lat);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({out_err, out_xs3} !== e) begin
      n_bad++;
      $display("FAIL basic_data: got err=%b xs3=%h, want err=%b xs3=%h", out_err, out_xs3, e[W], e[W-1:0]);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pulse: out_valid=%b one cycle after handshake, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[2];
    logic [W:0]   exps[2];
    logic [W:0]   e;
    int acc[2];
    int idx, got, cyc;
    bit a;
    words = '{16'h9999, 16'h0000};
    exps  = '{{1'b0, 16'hCCCC}, {1'b0, 16'h3333}};
    acc   = '{0, 0};
    idx = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    in_bcd    = words[0];
    in_valid  = 1'b1;
    while (got < 2 && cyc < 60) begin
      a = in_valid && in_ready;
      step();
      cyc++;
      if (a && idx < 2) begin
        acc[idx] = cyc;
        exp_q.push_back(exps[idx]);
        idx++;
        if (idx < 2) in_bcd = words[idx];
        else in_valid = 1'b0;
      end
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({out_err, out_xs3} !== e) begin
          n_bad++;
          $display("FAIL b2b_data%0d: got err=%b xs3=%h, want err=%b xs3=%h", got, out_err, out_xs3, e[W], e[W-1:0]);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (got !== 2) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results, want 2", got);
    end
    n_vec++;
    if (acc[1] - acc[0] !== 6) begin
      n_bad++;
      $display("FAIL b2b_spacing: accepts %0d cycles apart, want 6", acc[1] - acc[0]);
    end
    exp_q.delete();
    step();
  endtask

  task automatic test_error();
    int lat;
    logic [W:0] e;
    out_ready = 1'b1;
    exp_q.push_back({1'b1, 16'h4507});
    drive_word(16'h12A4);
    wait_valid(lat);
    e = exp_q.pop_front();
    n_vec++;
    if ({out_err, out_xs3} !== e) begin
      n_bad++;
      $display("FAIL err_sticky: got err=%b xs3=%h, want err=%b xs3=%h", out_err, out_xs3, e[W], e[W-1:0]);
    end
    step();
    exp_q.push_back({1'b0, 16'h3334});
    drive_word(16'h0001);
    wait_valid(lat);
    e = exp_q.pop_front();
    n_vec++;
    if ({out_err, out_xs3} !== e || lat !== 4) begin
      n_bad++;
      $display("FAIL err_cleared: got err=%b xs3=%h lat=%0d, want err=%b xs3=%h lat=4",
               out_err, out_xs3, lat, e[W], e[W-1:0]);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W:0] e;
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h3A47});
    drive_word(16'h0714);
    wait_valid(lat);
    e = exp_q.pop_front();
    in_valid = 1'b1;
    in_bcd   = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || {out_err, out_xs3} !== e || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: vld=%b err=%b xs3=%h rdy=%b, want 1 %b %h 0",
                 i, out_valid, out_err, out_xs3, in_ready, e[W], e[W-1:0]);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (out_valid !== 1'b1 || out_xs3 !== e[W-1:0]) begin
      n_bad++;
      $display("FAIL bp_before_hs: vld=%b xs3=%h, want 1 %h", out_valid, out_xs3, e[W-1:0]);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_after_hs: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [W:0] e;
    out_ready = 1'b1;
    drive_word(16'h4321);
    step();
    step();
    n_vec++;
    if (busy !== 1'b1 || out_xs3 !== 16'h0054) begin
      n_bad++;
      $display("FAIL mid_partial: busy=%b xs3=%h, want 1 0054", busy, out_xs3);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_xs3 !== '0 || busy !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: vld=%b xs3=%h busy=%b err=%b rdy=%b, want 0 0000 0 0 1",
               out_valid, out_xs3, busy, out_err, in_ready);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_no_pulse%0d: vld=%b busy=%b, want 0 0", i, out_valid, busy);
      end
    end
    exp_q.push_back({1'b0, 16'hBA98});
    drive_word(16'h8765);
    wait_valid(lat);
    e = exp_q.pop_front();
    n_vec++;
    if ({out_err, out_xs3} !== e || lat !== 4) begin
      n_bad++;
      $display("FAIL mid_recover: got err=%b xs3=%h lat=%0d, want err=%b xs3=%h lat=4",
               out_err, out_xs3, lat, e[W], e[W-1:0]);
    end
    step();
  endtask

  task automatic test_round_trip();
    int nxt, got, cyc;
    bit a;
    logic [W-1:0] w;
    logic [W-1:0] d;
    nxt = 1; got = 0; cyc = 0;
    rt_q.delete();
    out_ready = 1'b1;
    in_bcd    = to_bcd(0);
    in_valid  = 1'b1;
    while (got < NWORDS && cyc < 7 * NWORDS) begin
      a = in_valid && in_ready;
      step();
      cyc++;
      if (a) begin
        rt_q.push_back(in_bcd);
        if (nxt < NWORDS) begin
          in_bcd = to_bcd(nxt);
          nxt++;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && rt_q.size() > 0) begin
        w = rt_q.pop_front();
        d = xs3_decode(out_xs3);
        n_vec++;
        if (d !== w || out_err !== 1'b0) begin
          n_bad++;
          $display("FAIL round_trip: in=%h xs3=%h decoded=%h err=%b, want decoded=%h err=0",
                   w, out_xs3, d, out_err, w);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (got !== NWORDS) begin
      n_bad++;
      $display("FAIL round_trip_count: got %0d results, want %0d", got, NWORDS);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_backpressure();
    test_mid_reset();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
